// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with start-bit qualification and framing check
module uart_rx #(
   parameter int OVERSAMPLING = 8,
   parameter int DATA_BITS    = 8
) (
   input  logic                 sysclk_in,
   input  logic                 rst_in,
   input  logic                 divpulse_in,
   input  logic                 rx_serial_in,
   output logic [DATA_BITS-1:0] rx_data_out,
   output logic                 rx_valid_out,
   output logic                 rx_frame_err_out,
   output logic                 rx_busy_out
);

   localparam int TW = $clog2(OVERSAMPLING);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLING / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t               state;
   logic [1:0]           sync_q;
   logic                 rx_s;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift_q;

   // Two-flop synchroniser; resets to the idle (high) line level so reset never looks like a start bit
   always_ff @(posedge sysclk_in) begin
      if (rst_in) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_serial_in};
      end
   end

   assign rx_s = sync_q[1];

   // Frame state machine: every decision is taken on an oversampling tick; strobes are single-cycle
   always_ff @(posedge sysclk_in) begin
      if (rst_in) begin
         state            <= S_IDLE;
         tick_cnt         <= '0;
         bit_cnt          <= '0;
         shift_q          <= '0;
         rx_data_out      <= '0;
         rx_valid_out     <= 1'b0;
         rx_frame_err_out <= 1'b0;
         rx_busy_out      <= 1'b0;
      end else begin
         rx_valid_out     <= 1'b0;
         rx_frame_err_out <= 1'b0;
         if (divpulse_in) begin
            unique case (state)
               S_IDLE: begin
                  if (!rx_s) begin
                     state       <= S_START;
                     tick_cnt    <= '0;
                     rx_busy_out <= 1'b1;
                  end
               end

               S_START: begin
                  if (tick_cnt == TICK_MID) begin
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                     if (!rx_s) begin
                        state <= S_DATA;
                     end else begin
                        // Line went back high by mid-bit: a glitch, not a start bit
                        state       <= S_IDLE;
                        rx_busy_out <= 1'b0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_ONE;
                  end
               end

               S_DATA: begin
                  if (tick_cnt == TICK_LAST) begin
                     shift_q  <= {rx_s, shift_q[DATA_BITS-1:1]};
                     tick_cnt <= '0;
                     bit_cnt  <= bit_cnt + BIT_ONE;
                     if (bit_cnt == BIT_LAST) begin
                        state <= S_STOP;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_ONE;
                  end
               end

               S_STOP: begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     if (rx_s) begin
                        rx_data_out  <= shift_q;
                        rx_valid_out <= 1'b1;
                        rx_busy_out  <= 1'b0;
                        state        <= S_IDLE;
                     end else begin
                        // Stop bit low: report once, then wait out any break condition
                        rx_frame_err_out <= 1'b1;
                        state            <= S_WAIT_IDLE;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_ONE;
                  end
               end

               S_WAIT_IDLE: begin
                  if (rx_s) begin
                     state       <= S_IDLE;
                     rx_busy_out <= 1'b0;
                  end
               end

               default: begin
                  state       <= S_IDLE;
                  tick_cnt    <= '0;
                  rx_busy_out <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - vector table and scoreboard bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int DIV = 108;
   localparam int OS  = 8;
   localparam int BIT = DIV * OS;

   logic       sysclk   = 1'b0;
   logic       rst      = 1'b1;
   logic       divpulse = 1'b0;
   logic       rx_line  = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       rx_busy;

   int checks = 0;
   int errors = 0;
   int div_cnt = 0;

   typedef struct packed {
      logic       is_err;
      logic [7:0] data;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] last_good = 8'h00;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      bit         rand_gap;
   } vec_t;

   vec_t vecs[4];

   uart_rx #(.OVERSAMPLING(OS), .DATA_BITS(8)) dut (
      .sysclk_in        (sysclk),
      .rst_in           (rst),
      .divpulse_in      (divpulse),
      .rx_serial_in     (rx_line),
      .rx_data_out      (rx_data),
      .rx_valid_out     (rx_valid),
      .rx_frame_err_out (rx_err),
      .rx_busy_out      (rx_busy)
   );

   always #5 sysclk = ~sysclk;

   // Oversampling tick generator
   always @(posedge sysclk) begin
      if (div_cnt == DIV - 1) begin
         div_cnt  <= 0;
         divpulse <= 1'b1;
      end else begin
         div_cnt  <= div_cnt + 1;
         divpulse <= 1'b0;
      end
   end

   // Scoreboard monitor: every strobe must match the oldest expected frame result
   always @(negedge sysclk) begin : monitor
      exp_t e;
      if (rx_valid && rx_err) begin
         checks++;
         errors++;
         $display("FAIL strobe_overlap: valid=1 err=1, required at most one");
      end
      if (rx_valid || rx_err) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: valid=%0b err=%0b data=%02h, required no strobe",
                     rx_valid, rx_err, rx_data);
         end else begin
            e = sbq.pop_front();
            if (rx_err !== e.is_err || rx_valid !== !e.is_err || rx_data !== e.data) begin
               errors++;
               $display("FAIL frame_result: valid=%0b err=%0b data=%02h, required err=%0b data=%02h",
                        rx_valid, rx_err, rx_data, e.is_err, e.data);
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic send_bit(input logic v);
      rx_line = v;
      repeat (BIT) @(negedge sysclk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      if (stop) begin
         sbq.push_back({1'b0, d});
         last_good = d;
      end else begin
         sbq.push_back({1'b1, last_good});
      end
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   task automatic rand_gap();
      repeat ($urandom_range(BIT / 4, BIT / 4 + DIV - 1)) @(negedge sysclk);
   endtask

   task automatic expect_drain(input string name);
      int n = 0;
      while (sbq.size() != 0 && n < 2 * BIT) begin
         @(negedge sysclk);
         n++;
      end
      check(name, sbq.size(), 0);
   endtask

   initial begin
      vecs[0] = '{data: 8'h00, stop: 1'b1, rand_gap: 1'b1};
      vecs[1] = '{data: 8'hFF, stop: 1'b1, rand_gap: 1'b0};
      vecs[2] = '{data: 8'hA5, stop: 1'b1, rand_gap: 1'b0};
      vecs[3] = '{data: 8'h61, stop: 1'b1, rand_gap: 1'b1};

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge sysclk);
      check("reset_data", rx_data, 8'h00);
      check("reset_valid", rx_valid, 0);
      check("reset_err", rx_err, 0);
      check("reset_busy", rx_busy, 0);
      rst = 1'b0;
      repeat (BIT) @(negedge sysclk);

      // Glitch of two ticks must be rejected, then a real frame decodes
      repeat ($urandom_range(0, DIV - 1)) @(negedge sysclk);
      rx_line = 1'b0;
      repeat (2 * DIV) @(negedge sysclk);
      check("glitch_busy_during", rx_busy, 1);
      rx_line = 1'b1;
      repeat (BIT) @(negedge sysclk);
      check("glitch_busy_after", rx_busy, 0);
      check("glitch_no_strobe", sbq.size(), 0);
      rand_gap();
      send_frame(8'h62, 1'b1);
      expect_drain("frame_62_drain");

      // Table: back-to-back 0x00/0xFF/0xA5, then a single 0x61
      for (int i = 0; i < 4; i++) begin
         if (vecs[i].rand_gap) rand_gap();
         send_frame(vecs[i].data, vecs[i].stop);
      end
      expect_drain("table_drain");
      check("single_busy_after", rx_busy, 0);
      check("single_data_61", rx_data, 8'h61);

      // Framing error followed by a 20-bit break
      send_frame(8'h55, 1'b0);
      repeat (10 * BIT) @(negedge sysclk);
      check("break_err_seen", sbq.size(), 0);
      check("break_busy_held", rx_busy, 1);
      repeat (10 * BIT) @(negedge sysclk);
      check("break_data_held", rx_data, 8'h61);
      rx_line = 1'b1;
      repeat (BIT) @(negedge sysclk);
      check("break_busy_released", rx_busy, 0);
      rand_gap();
      send_frame(8'h63, 1'b1);
      expect_drain("frame_63_drain");
      check("frame_63_data", rx_data, 8'h63);

      // Reset in the middle of data bit 4 of 0x64
      rand_gap();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(vecs[0].data[i] | (8'h64 >> i) & 8'h01);
      rx_line = 1'b0;
      repeat (BIT / 2) @(negedge sysclk);
      rst     = 1'b1;
      rx_line = 1'b1;
      @(negedge sysclk);
      check("midreset_data", rx_data, 8'h00);
      check("midreset_valid", rx_valid, 0);
      check("midreset_err", rx_err, 0);
      check("midreset_busy", rx_busy, 0);
      rst = 1'b0;
      repeat (BIT) @(negedge sysclk);
      check("midreset_no_strobe", sbq.size(), 0);
      send_frame(8'h2E, 1'b1);
      expect_drain("frame_2e_drain");
      check("final_busy", rx_busy, 0);
      check("final_data", rx_data, 8'h2E);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
